// File: rtl/gpu_cmd_sequencer.sv
// CPU-to-GPU command sequencer: buffers CPU commands, replays them as timed GPU strobes,
// expands CLEAR into a home-and-fill sequence, and tracks a shadow copy of the text cursor.
module gpu_cmd_sequencer #(
  parameter int TEXT_W     = 80,
  parameter int TEXT_H     = 60,
  parameter int FIFO_DEPTH = 4,
  parameter int STROBE_HI  = 2,
  parameter int STROBE_LO  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [1:0] gpu_interrupt_out,
  output logic [7:0] gpu_data_out,
  output logic       gpu_interrupt_enable,
  output logic       busy,
  output logic [6:0] cursor_x,
  output logic [5:0] cursor_y
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_STORE = 2'b00;
  localparam logic [1:0] OP_MOVE  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [12:0] FILL_LAST = 13'(TEXT_W * TEXT_H - 1);
  localparam logic [7:0]  HI_LAST   = 8'(STROBE_HI - 1);
  localparam logic [7:0]  LO_LAST   = 8'(STROBE_LO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HI, S_LO, S_CLR_HX, S_CLR_HY, S_CLR_FILL
  } state_t;

  // Which clear step the strobe in flight belongs to, so LO knows where to continue.
  typedef enum logic [1:0] {CLR_NONE, CLR_X, CLR_Y, CLR_STORE} clr_t;

  // ---------------- command FIFO ----------------
  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full, empty, push, pop;
  logic [9:0]    head;

  state_t state_reg, state_next;

  assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_reg == S_IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- sequencing FSM ----------------
  clr_t        clr_reg, clr_next;
  logic [7:0]  phase_cnt_reg, phase_cnt_next;
  logic [12:0] fill_cnt_reg, fill_cnt_next;
  logic [7:0]  fill_byte_reg, fill_byte_next;
  logic [1:0]  op_reg, op_next;
  logic [7:0]  data_reg, data_next;
  logic [6:0]  cursor_x_reg, cursor_x_next;
  logic [5:0]  cursor_y_reg, cursor_y_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      clr_reg       <= CLR_NONE;
      phase_cnt_reg <= '0;
      fill_cnt_reg  <= '0;
      fill_byte_reg <= '0;
      op_reg        <= '0;
      data_reg      <= '0;
      cursor_x_reg  <= '0;
      cursor_y_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      clr_reg       <= clr_next;
      phase_cnt_reg <= phase_cnt_next;
      fill_cnt_reg  <= fill_cnt_next;
      fill_byte_reg <= fill_byte_next;
      op_reg        <= op_next;
      data_reg      <= data_next;
      cursor_x_reg  <= cursor_x_next;
      cursor_y_reg  <= cursor_y_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_next       = clr_reg;
    phase_cnt_next = phase_cnt_reg;
    fill_cnt_next  = fill_cnt_reg;
    fill_byte_next = fill_byte_reg;
    op_next        = op_reg;
    data_next      = data_reg;
    case (state_reg)
      S_IDLE: begin
        if (!empty) begin
          if (head[9:8] == OP_CLEAR) begin
            fill_byte_next = head[7:0];
            state_next     = S_CLR_HX;
          end else begin
            op_next    = head[9:8];
            data_next  = head[7:0];
            clr_next   = CLR_NONE;
            state_next = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        phase_cnt_next = '0;
        state_next     = S_HI;
      end
      S_HI: begin
        if (phase_cnt_reg == HI_LAST) begin
          phase_cnt_next = '0;
          state_next     = S_LO;
        end else begin
          phase_cnt_next = phase_cnt_reg + 1'b1;
        end
      end
      S_LO: begin
        if (phase_cnt_reg == LO_LAST) begin
          phase_cnt_next = '0;
          case (clr_reg)
            CLR_X: state_next = S_CLR_HY;
            CLR_Y: state_next = S_CLR_FILL;
            CLR_STORE: begin
              // Fill stores chain straight into the next SETUP with op/data unchanged.
              if (fill_cnt_reg == FILL_LAST) begin
                clr_next   = CLR_NONE;
                state_next = S_IDLE;
              end else begin
                fill_cnt_next = fill_cnt_reg + 1'b1;
                state_next    = S_SETUP;
              end
            end
            default: state_next = S_IDLE;
          endcase
        end else begin
          phase_cnt_next = phase_cnt_reg + 1'b1;
        end
      end
      S_CLR_HX: begin
        if (cursor_x_reg != '0) begin
          op_next    = OP_MOVE;
          data_next  = {1'b1, 7'd0 - cursor_x_reg};
          clr_next   = CLR_X;
          state_next = S_SETUP;
        end else begin
          state_next = S_CLR_HY;
        end
      end
      S_CLR_HY: begin
        if (cursor_y_reg != '0) begin
          op_next    = OP_MOVE;
          data_next  = {2'b00, 6'd0 - cursor_y_reg};
          clr_next   = CLR_Y;
          state_next = S_SETUP;
        end else begin
          state_next = S_CLR_FILL;
        end
      end
      S_CLR_FILL: begin
        op_next       = OP_STORE;
        data_next     = fill_byte_reg;
        fill_cnt_next = '0;
        clr_next      = CLR_STORE;
        state_next    = S_SETUP;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shadow cursor follows the GPU on the first HI cycle of every strobe.
  always_comb begin
    cursor_x_next = cursor_x_reg;
    cursor_y_next = cursor_y_reg;
    if (state_reg == S_HI && phase_cnt_reg == '0) begin
      if (op_reg == OP_STORE) begin
        if (cursor_x_reg == 7'(TEXT_W - 1)) begin
          cursor_x_next = '0;
          cursor_y_next = (cursor_y_reg == 6'(TEXT_H - 1)) ? 6'd0 : cursor_y_reg + 6'd1;
        end else begin
          cursor_x_next = cursor_x_reg + 7'd1;
        end
      end else if (op_reg == OP_MOVE) begin
        if (data_reg[7]) cursor_x_next = cursor_x_reg + data_reg[6:0];
        else             cursor_y_next = cursor_y_reg + data_reg[5:0];
      end
    end
  end

  assign gpu_interrupt_out    = op_reg;
  assign gpu_data_out         = data_reg;
  assign gpu_interrupt_enable = (state_reg == S_HI);
  assign busy                 = !empty || (state_reg != S_IDLE);
  assign cursor_x             = cursor_x_reg;
  assign cursor_y             = cursor_y_reg;

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Directed self-checking bench for gpu_cmd_sequencer; every GPU strobe is logged on its rising edge.
module tb_gpu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [1:0] gpu_interrupt_out;
  logic [7:0] gpu_data_out;
  logic       gpu_interrupt_enable;
  logic       busy;
  logic [6:0] cursor_x;
  logic [5:0] cursor_y;

  int checks = 0;
  int failures = 0;
  logic [9:0] log_q[$];

  gpu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .gpu_interrupt_out(gpu_interrupt_out), .gpu_data_out(gpu_data_out),
    .gpu_interrupt_enable(gpu_interrupt_enable), .busy(busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  always @(posedge gpu_interrupt_enable) log_q.push_back({gpu_interrupt_out, gpu_data_out});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) timeout_fail("push_ready");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    @(negedge clk);
    while (busy && n < max_cycles) begin @(negedge clk); n++; end
    if (busy) timeout_fail("wait_idle");
  endtask

  task automatic check_cursor(input string tag, input logic [6:0] x, input logic [5:0] y);
    check(tag, {cursor_x, cursor_y}, {x, y});
  endtask

  initial begin
    logic [7:1] en_exp;
    logic [7:1] busy_exp;
    int en_cycles;
    int idx, stall_at, n, bad_store, op11, log_len;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_en", gpu_interrupt_enable, 0);
    check("rst_opdata", {gpu_interrupt_out, gpu_data_out}, 0);
    check_cursor("rst_cursor", 0, 0);
    rst_n = 1'b1;

    // Single STORE: cycle-accurate strobe shape
    en_exp   = 7'b0001100;
    busy_exp = 7'b0111111;
    en_cycles = 0;
    push(2'b00, 8'h41);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("t1_en_c%0d", i), gpu_interrupt_enable, en_exp[i]);
      check($sformatf("t1_busy_c%0d", i), busy, busy_exp[i]);
      if (gpu_interrupt_enable) en_cycles++;
      if (i == 2) check("t1_setup_opdata", {gpu_interrupt_out, gpu_data_out}, {2'b00, 8'h41});
    end
    check("t1_en_cycles", en_cycles, 2);
    check_cursor("t1_cursor", 1, 0);
    check("t1_log_len", log_q.size(), 1);
    if (log_q.size() > 0) check("t1_log0", log_q[0], {2'b00, 8'h41});

    // Cursor wrap on STORE
    push(2'b01, 8'hCD); wait_idle(100); check_cursor("t2_c78_0", 78, 0);
    push(2'b00, 8'h01); wait_idle(100); check_cursor("t2_c79_0", 79, 0);
    push(2'b00, 8'h02); wait_idle(100); check_cursor("t2_c0_1", 0, 1);
    push(2'b00, 8'h03); wait_idle(100); check_cursor("t2_c1_1", 1, 1);
    push(2'b01, 8'hCE); push(2'b01, 8'h3A); wait_idle(100); check_cursor("t2_c79_59", 79, 59);
    push(2'b00, 8'h04); wait_idle(100); check_cursor("t2_wrap00", 0, 0);

    // Back-to-back MOVEs
    log_q.delete();
    push(2'b01, 8'h85); push(2'b01, 8'h03); wait_idle(100);
    check("t3_log_len", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("t3_log0", log_q[0], {2'b01, 8'h85});
      check("t3_log1", log_q[1], {2'b01, 8'h03});
    end
    check_cursor("t3_cursor", 5, 3);

    // CLEAR from (10,7), with a DISPLAY queued behind it
    push(2'b01, 8'h85); push(2'b01, 8'h04); wait_idle(100);
    check_cursor("t4_pre", 10, 7);
    log_q.delete();
    push(2'b11, 8'h20);
    push(2'b10, 8'h77);
    wait_idle(40000);
    check("t4_log_len", log_q.size(), 4803);
    bad_store = 0; op11 = 0;
    foreach (log_q[i]) begin
      if (log_q[i][9:8] == 2'b11) op11++;
      if (i >= 2 && i < 4802 && log_q[i] !== {2'b00, 8'h20}) bad_store++;
    end
    if (log_q.size() >= 4803) begin
      check("t4_home_x", log_q[0], {2'b01, 8'hF6});
      check("t4_home_y", log_q[1], {2'b01, 8'h39});
      check("t4_after_clear", log_q[4802], {2'b10, 8'h77});
    end
    check("t4_bad_stores", bad_store, 0);
    check("t4_op11_seen", op11, 0);
    check_cursor("t4_cursor", 0, 0);

    // FIFO backpressure with 6 held DISPLAY commands behind a running one
    log_q.delete();
    push(2'b10, 8'h00);
    idx = 0; stall_at = -1; n = 0;
    while (idx < 6 && n < 300) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 8'h10 + 8'(idx);
      if (cmd_ready) begin
        @(posedge clk);
        idx++;
      end else if (stall_at < 0) begin
        stall_at = idx;
      end
      n++;
    end
    #1 cmd_valid = 1'b0;
    check("t5_accepted", idx, 6);
    check("t5_stall_after", stall_at, 4);
    wait_idle(200);
    check("t5_log_len", log_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < log_q.size())
        check($sformatf("t5_log%0d", i), log_q[i], {2'b10, (i == 0) ? 8'h00 : 8'(8'h10 + i - 1)});
    end

    // Asynchronous reset during HI of a STORE
    push(2'b01, 8'h83); wait_idle(100); check_cursor("t6_pre", 3, 0);
    push(2'b00, 8'h55); push(2'b00, 8'h56);
    n = 0;
    while (!gpu_interrupt_enable && n < 50) begin @(negedge clk); n++; end
    if (!gpu_interrupt_enable) timeout_fail("t6_wait_hi");
    rst_n = 1'b0;
    #1;
    check("t6_en_drop", gpu_interrupt_enable, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", cmd_ready, 1);
    check_cursor("t6_cursor", 0, 0);
    log_len = log_q.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_no_strobes", log_q.size(), log_len);
    check("t6_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
